// File: rtl/lsu_pkg.sv
// lsu_pkg: access sizes, FSM states and the alignment rule shared by the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [1:0] {IDLE, MERGE, WRITE, RESP} lsu_state_e;
    function automatic logic is_misaligned(input logic [1:0] addr, input size_e size);
        return size == SZ_ILL || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus of the load/store unit
interface load_store_unit_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    lsu_pkg::size_e        req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_misaligned;
    logic                  mem_w_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_w_en, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_w_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align import lsu_pkg::*; #(parameter int DATA_WIDTH = 32) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            lane,
    input  size_e                 size,
    input  logic                  uns,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] ext,
    output logic [DATA_WIDTH-1:0] merged
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[8*lane +: 8];
    assign h = lane[1] ? rdata[31:16] : rdata[15:0];
    assign ext = size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
                 size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : rdata;
    always_comb begin
        merged = rdata;
        if (size == SZ_BYTE) merged[8*lane +: 8] = wdata[7:0];
        else if (size == SZ_HALF) merged[16*lane[1] +: 16] = wdata[15:0];
        else merged = wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word requests into word accesses, with read-modify-write for sub-word stores
module load_store_unit import lsu_pkg::*; #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    load_store_unit_if.slave bus
);
    lsu_state_e            state;
    logic [ADDR_WIDTH-1:0] lat_addr;
    size_e                 lat_size, cur_size;
    logic                  lat_uns, idle, err;
    logic [DATA_WIDTH-1:0] lat_wdata, ld_data, st_data;
    logic [1:0]            cur_lane;
    assign idle = state == IDLE;
    assign err = is_misaligned(bus.req_addr[1:0], bus.req_size);
    assign bus.req_ready = idle;
    assign bus.mem_addr = {idle ? bus.req_addr[ADDR_WIDTH-1:2] : lat_addr[ADDR_WIDTH-1:2], 2'b00};
    // One aligner serves both the live request (IDLE loads) and the latched one (MERGE)
    assign cur_lane = idle ? bus.req_addr[1:0] : lat_addr[1:0];
    assign cur_size = idle ? bus.req_size : lat_size;
    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rdata(bus.mem_rdata), .lane(cur_lane), .size(cur_size),
        .uns(idle ? bus.req_unsigned : lat_uns), .wdata(lat_wdata),
        .ext(ld_data), .merged(st_data)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_misaligned <= 1'b0;
            bus.mem_w_en <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_wdata <= '0;
            lat_addr <= '0;
            lat_size <= SZ_BYTE;
            lat_uns <= 1'b0;
            lat_wdata <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_w_en <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    lat_addr <= bus.req_addr;
                    lat_size <= bus.req_size;
                    lat_uns <= bus.req_unsigned;
                    lat_wdata <= bus.req_wdata;
                    bus.resp_misaligned <= err;
                    if (err || !bus.req_we) begin
                        if (!err) bus.resp_rdata <= ld_data;
                        bus.resp_valid <= 1'b1;
                        state <= RESP;
                    end else if (bus.req_size == SZ_WORD) begin
                        bus.mem_wdata <= bus.req_wdata;
                        bus.mem_w_en <= 1'b1;
                        state <= WRITE;
                    end else state <= MERGE;
                end
                MERGE: begin
                    bus.mem_wdata <= st_data;
                    bus.mem_w_en <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    bus.resp_valid <= 1'b1;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a response/write scoreboard against a behavioural word memory
module tb_load_store_unit;
    import lsu_pkg::*;
    typedef struct {logic [31:0] rdata; bit mis; int cyc;} resp_t;
    typedef struct {int cyc; logic [31:0] addr;} wr_t;
    logic clk = 1'b0, rst_n;
    logic [31:0] mem [0:63];
    logic pk_en = 1'b0;
    logic [5:0] pk_idx;
    logic [31:0] pk_val;
    int cyc = 0, checks = 0, errors = 0;
    resp_t exp_q[$];
    wr_t wr_q[$];
    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk)
        if (bus.mem_w_en) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        else if (pk_en) mem[pk_idx] <= pk_val;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        resp_t e;
        wr_t w;
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_misaligned", {31'd0, bus.resp_misaligned}, {31'd0, e.mis});
            end
        end
        if (bus.mem_w_en) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
                w = wr_q.pop_front();
                chk("write_cycle", cyc, w.cyc);
                chk("write_addr", bus.mem_addr, w.addr);
            end
        end
    end
    task automatic poke(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pk_en = 1'b1; pk_idx = idx; pk_val = val;
        @(posedge clk); #1 pk_en = 1'b0;
    endtask
    task automatic drive(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size_e'(sz);
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
    endtask
    // wlat/rlat are cycles after the accept cycle; wlat 0 means no write expected
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input bit mis,
                         input int wlat, input int rlat);
        int c;
        bit busy_ok = 1'b1;
        @(negedge clk);
        chk("ready_idle", {31'd0, bus.req_ready}, 32'd1);
        c = cyc;
        exp_q.push_back('{exp_rd, mis, c + rlat});
        if (wlat > 0) wr_q.push_back('{c + wlat, {a[31:2], 2'b00}});
        drive(we, sz, uns, a, wd);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (rlat) begin
            @(negedge clk);
            if (bus.req_ready) busy_ok = 1'b0;
        end
        #1;
        chk("ready_busy", {31'd0, busy_ok}, 32'd1);
        chk("resp_pending", exp_q.size(), 32'd0);
        chk("write_pending", wr_q.size(), 32'd0);
        exp_q.delete();
        wr_q.delete();
    endtask
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        #1;
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_misaligned", {31'd0, bus.resp_misaligned}, 32'd0);
        chk("rst_mem_w_en", {31'd0, bus.mem_w_en}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        poke(2, 32'h8899AABB);
        poke(4, 32'h11223344);
        issue(0, 2'b00, 0, 32'h0B, 0, 32'hFFFFFF88, 0, 0, 1);
        issue(0, 2'b00, 1, 32'h0B, 0, 32'h00000088, 0, 0, 1);
        issue(1, 2'b00, 0, 32'h11, 32'h55, 32'h00000088, 0, 2, 3);
        chk("mem_sb", mem[4], 32'h11225544);
        poke(4, 32'h11223344);
        issue(1, 2'b01, 0, 32'h12, 32'hBEEF, 32'h00000088, 0, 2, 3);
        chk("mem_sh", mem[4], 32'hBEEF3344);
        issue(0, 2'b01, 0, 32'h12, 0, 32'hFFFFBEEF, 0, 0, 1);
        issue(0, 2'b01, 1, 32'h10, 0, 32'h00003344, 0, 0, 1);
        issue(0, 2'b10, 0, 32'h06, 0, 32'h00003344, 1, 0, 1);
        issue(1, 2'b01, 0, 32'h03, 32'hFFFF, 32'h00003344, 1, 0, 1);
        issue(1, 2'b11, 0, 32'h00, 32'hFFFFFFFF, 32'h00003344, 1, 0, 1);
        chk("mem_err0", mem[0], 32'h0);
        chk("mem_err1", mem[1], 32'h0);
        issue(0, 2'b10, 0, 32'h08, 0, 32'h8899AABB, 0, 0, 1);
        issue(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h8899AABB, 0, 1, 2);
        chk("mem_sw", mem[8], 32'hDEADBEEF);
        issue(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 0, 1);
        issue(1, 2'b00, 0, 32'h23, 32'h77, 32'hDEADBEEF, 0, 2, 3);
        chk("mem_sb_lane3", mem[8], 32'h77ADBEEF);
        issue(0, 2'b00, 0, 32'h23, 0, 32'h00000077, 0, 0, 1);
        poke(12, 32'hCAFEF00D);
        @(negedge clk);
        drive(1, 2'b00, 0, 32'h31, 32'h5A);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mid_rst_mem_w_en", {31'd0, bus.mem_w_en}, 32'd0);
        chk("mid_rst_misaligned", {31'd0, bus.resp_misaligned}, 32'd0);
        chk("mid_rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_rst_mem", mem[12], 32'hCAFEF00D);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
